// File: rtl/foot_pkg.sv
// -----------------------------------------------------------------------------
// foot_pkg
// Shared definitions for the foot-sensor burst buffer: nominal packet length,
// event counter width and the state encodings of the fill and drain FSMs.
// No ports (package).
// -----------------------------------------------------------------------------
package foot_pkg;

    // Nominal foot-sensor packet length in bytes
    localparam int FOOT_PKT_LEN = 40;

    // Width of the wrapping packet counters
    localparam int CNT_W = 16;

    typedef enum logic [0:0] {
        FILL_IDLE = 1'b0,
        FILL_RUN  = 1'b1
    } fill_state_e;

    typedef enum logic [1:0] {
        DR_IDLE  = 2'd0,
        DR_READ  = 2'd1,
        DR_BURST = 2'd2,
        DR_TAIL  = 2'd3
    } drain_state_e;

endpackage

// File: rtl/foot_pp_ram.sv
// -----------------------------------------------------------------------------
// foot_pp_ram
// Simple dual-port byte RAM holding two ping-pong banks of DEPTH bytes each.
// The bank select is the top address bit. Read data is registered (1 cycle).
//
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_addr  in   {bank, byte address} for the write
//   wr_data  in   byte to store
//   rd_en    in   read strobe
//   rd_addr  in   {bank, byte address} for the read
//   rd_data  out  registered read byte, valid the cycle after rd_en
// -----------------------------------------------------------------------------
module foot_pp_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(2 * DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem_q [2*DEPTH];
    logic [7:0] rd_data_q;

    // Storage only: no reset on the array or the read register
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/foot_burst_buffer.sv
// -----------------------------------------------------------------------------
// foot_burst_buffer
// Collects sparse single-cycle UART byte strobes into a packet (closed by an
// idle gap of GAP_CYCLES clocks) and replays each accepted packet as one
// contiguous burst, one byte per clock, for the downstream foot packet parser.
// Two ping-pong banks let a new packet fill while the previous one drains.
//
// Ports:
//   c             in   clock
//   rst_n         in   asynchronous active-low reset
//   in_d[7:0]     in   byte from the UART receiver
//   in_dv         in   one-cycle strobe qualifying in_d
//   rxd[7:0]      out  burst byte to the parser, 0 when rxdv is low
//   rxdv          out  high for exactly len consecutive cycles per packet
//   pkt_ok_cnt    out  packets handed to the drain side (wraps)
//   pkt_drop_cnt  out  packets dropped: runt, overlong or collision (wraps)
// -----------------------------------------------------------------------------
module foot_burst_buffer
    import foot_pkg::*;
#(
    parameter int MAX_LEN    = 64,
    parameter int MIN_LEN    = FOOT_PKT_LEN,
    parameter int GAP_CYCLES = 1000
) (
    input  logic             c,
    input  logic             rst_n,
    input  logic [7:0]       in_d,
    input  logic             in_dv,
    output logic [7:0]       rxd,
    output logic             rxdv,
    output logic [CNT_W-1:0] pkt_ok_cnt,
    output logic [CNT_W-1:0] pkt_drop_cnt
);

    localparam int AW    = $clog2(MAX_LEN);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES);

    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_MIN  = LEN_W'(MIN_LEN);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    // Fill side state
    fill_state_e       fill_st_q, fill_st_d;
    logic [LEN_W-1:0]  wr_len_q, wr_len_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic              too_long_q, too_long_d;
    logic              fill_bank_q, fill_bank_d;
    logic [CNT_W-1:0]  ok_cnt_q, ok_cnt_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    // Drain side state
    drain_state_e      dr_st_q, dr_st_d;
    logic              rd_bank_q, rd_bank_d;
    logic [LEN_W-1:0]  rd_len_q, rd_len_d;
    logic [LEN_W-1:0]  out_cnt_q, out_cnt_d;

    // RAM ports
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [7:0]        rd_data;
    logic              handoff;

    // -------------------------------------------------------------------------
    // Fill FSM: packet assembly and close/accept/drop decision
    // -------------------------------------------------------------------------
    always_comb begin
        fill_st_d   = fill_st_q;
        wr_len_d    = wr_len_q;
        gap_cnt_d   = gap_cnt_q;
        too_long_d  = too_long_q;
        fill_bank_d = fill_bank_q;
        ok_cnt_d    = ok_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        wr_en       = 1'b0;
        wr_addr     = '0;
        handoff     = 1'b0;

        if (fill_st_q == FILL_IDLE) begin
            if (in_dv) begin
                wr_en      = 1'b1;
                wr_addr    = '0;
                wr_len_d   = LEN_W'(1);
                gap_cnt_d  = '0;
                too_long_d = 1'b0;
                fill_st_d  = FILL_RUN;
            end
        end else begin
            if (in_dv) begin
                gap_cnt_d = '0;
                if (wr_len_q < LEN_MAX) begin
                    wr_en    = 1'b1;
                    wr_addr  = wr_len_q[AW-1:0];
                    wr_len_d = wr_len_q + LEN_W'(1);
                end else begin
                    // Overflow bytes are discarded; the packet is dropped at close
                    too_long_d = 1'b1;
                end
            end else if (gap_cnt_q == GAP_LAST) begin
                // Close: GAP_CYCLES idle clocks since the last byte
                fill_st_d  = FILL_IDLE;
                wr_len_d   = '0;
                too_long_d = 1'b0;
                if (!too_long_q && (wr_len_q >= LEN_MIN) && (dr_st_q == DR_IDLE)) begin
                    handoff     = 1'b1;
                    fill_bank_d = ~fill_bank_q;
                    ok_cnt_d    = ok_cnt_q + CNT_W'(1);
                end else begin
                    // Runt, overlong, or drain still busy (collision)
                    drop_cnt_d = drop_cnt_q + CNT_W'(1);
                end
            end else begin
                gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Drain FSM: READ primes the registered RAM, BURST streams one byte per
    // clock while prefetching the next address, TAIL forces one low cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        dr_st_d   = dr_st_q;
        rd_bank_d = rd_bank_q;
        rd_len_d  = rd_len_q;
        out_cnt_d = out_cnt_q;
        rd_en     = 1'b0;
        rd_addr   = '0;

        case (dr_st_q)
            DR_IDLE: begin
                if (handoff) begin
                    rd_bank_d = fill_bank_q;
                    rd_len_d  = wr_len_q;
                    dr_st_d   = DR_READ;
                end
            end
            DR_READ: begin
                rd_en     = 1'b1;
                rd_addr   = '0;
                out_cnt_d = '0;
                dr_st_d   = DR_BURST;
            end
            DR_BURST: begin
                // Prefetch byte out_cnt+1; a read past len is harmless
                rd_en     = 1'b1;
                rd_addr   = out_cnt_q[AW-1:0] + AW'(1);
                out_cnt_d = out_cnt_q + LEN_W'(1);
                if (out_cnt_q == rd_len_q - LEN_W'(1)) begin
                    dr_st_d = DR_TAIL;
                end
            end
            DR_TAIL: begin
                dr_st_d = DR_IDLE;
            end
            default: begin
                dr_st_d = DR_IDLE;
            end
        endcase
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            fill_st_q   <= FILL_IDLE;
            wr_len_q    <= '0;
            gap_cnt_q   <= '0;
            too_long_q  <= 1'b0;
            fill_bank_q <= 1'b0;
            ok_cnt_q    <= '0;
            drop_cnt_q  <= '0;
            dr_st_q     <= DR_IDLE;
            rd_bank_q   <= 1'b0;
            rd_len_q    <= '0;
            out_cnt_q   <= '0;
        end else begin
            fill_st_q   <= fill_st_d;
            wr_len_q    <= wr_len_d;
            gap_cnt_q   <= gap_cnt_d;
            too_long_q  <= too_long_d;
            fill_bank_q <= fill_bank_d;
            ok_cnt_q    <= ok_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            dr_st_q     <= dr_st_d;
            rd_bank_q   <= rd_bank_d;
            rd_len_q    <= rd_len_d;
            out_cnt_q   <= out_cnt_d;
        end
    end

    foot_pp_ram #(
        .DEPTH (MAX_LEN),
        .AW    (AW + 1)
    ) u_ram (
        .clk     (c),
        .wr_en   (wr_en),
        .wr_addr ({fill_bank_q, wr_addr}),
        .wr_data (in_d),
        .rd_en   (rd_en),
        .rd_addr ({rd_bank_q, rd_addr}),
        .rd_data (rd_data)
    );

    // Decoded straight from the state flop so reset drops rxdv without a clock
    assign rxdv         = (dr_st_q == DR_BURST);
    assign rxd          = rxdv ? rd_data : 8'h00;
    assign pkt_ok_cnt   = ok_cnt_q;
    assign pkt_drop_cnt = drop_cnt_q;

endmodule
